// File: rtl/osd_bram_arbiter.sv
// osd_bram_arbiter: shares one single-port synchronous-read OSD BRAM between
// the SPI RAM slave (sparse one-cycle rd/wr strobes) and the OSD video fetcher
// (level request / ack). Video has fixed priority. An SPI access is latched
// into a single pending slot and issued in the next free cycle.
// Optional build macro: OSD_ARB_STATS_EN enables the stat_wait counter.
module osd_bram_arbiter #(
  parameter int         c_addr_bits = 32,
  parameter int         c_bram_bits = 12,
  parameter logic [7:0] c_addr_osd  = 8'hFD
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   spi_rd,
  input  logic                   spi_wr,
  input  logic [c_addr_bits-1:0] spi_addr,
  input  logic [7:0]             spi_wdata,
  output logic [7:0]             spi_rdata,
  output logic                   spi_busy,
  output logic                   spi_overrun,
  input  logic                   overrun_clr,
  input  logic                   vid_req,
  input  logic [c_bram_bits-1:0] vid_addr,
  output logic                   vid_ack,
  output logic [7:0]             vid_rdata,
  output logic [c_bram_bits-1:0] bram_addr,
  output logic                   bram_we,
  output logic [7:0]             bram_wdata,
  input  logic [7:0]             bram_rdata,
  output logic [15:0]            stat_wait
);

  // Pending SPI slot
  logic                   pend_valid_r;
  logic                   pend_we_r;
  logic [c_bram_bits-1:0] pend_addr_r;
  logic [7:0]             pend_wdata_r;

  // Issue pipeline tracking: stage 1 = address presented, stage 2 = data out
  logic vid_inflight_r;
  logic s1_vid_r;
  logic s2_vid_r;
  logic s1_spi_r;
  logic s1_spi_rd_r;
  logic s2_spi_rd_r;

  // Output registers
  logic [7:0]             spi_rdata_r;
  logic                   spi_busy_r;
  logic                   spi_overrun_r;
  logic                   vid_ack_r;
  logic [7:0]             vid_rdata_r;
  logic [c_bram_bits-1:0] bram_addr_r;
  logic                   bram_we_r;
  logic [7:0]             bram_wdata_r;

  // Combinational decisions for the current edge
  logic match_s;
  logic issue_vid_s;
  logic issue_spi_s;
  logic pend_valid_nxt_s;
  logic s1_spi_rd_nxt_s;
  logic busy_nxt_s;
  logic overrun_set_s;

  // Address bits between the BRAM window and the select byte are don't-care
  logic unused_addr_s;
  assign unused_addr_s = ^spi_addr[c_addr_bits-9:c_bram_bits];

  // Strobe decode, slot arbitration and next-state of the SPI tracking
  always_comb begin
    match_s          = 1'b0;
    issue_vid_s      = 1'b0;
    issue_spi_s      = 1'b0;
    pend_valid_nxt_s = pend_valid_r;
    s1_spi_rd_nxt_s  = 1'b0;
    busy_nxt_s       = 1'b0;
    overrun_set_s    = 1'b0;

    if ((spi_rd || spi_wr) && (spi_addr[c_addr_bits-1 -: 8] == c_addr_osd)) begin
      match_s = 1'b1;
    end else begin
      match_s = 1'b0;
    end

    // Video wins whenever it asks and has nothing outstanding
    if (vid_req && !vid_inflight_r) begin
      issue_vid_s = 1'b1;
      issue_spi_s = 1'b0;
    end else if (pend_valid_r) begin
      issue_vid_s = 1'b0;
      issue_spi_s = 1'b1;
    end else begin
      issue_vid_s = 1'b0;
      issue_spi_s = 1'b0;
    end

    if (match_s) begin
      pend_valid_nxt_s = 1'b1;
    end else if (issue_spi_s) begin
      pend_valid_nxt_s = 1'b0;
    end else begin
      pend_valid_nxt_s = pend_valid_r;
    end

    // Replacing an access that is issued on this same edge is not an overrun
    overrun_set_s   = match_s && pend_valid_r && !issue_spi_s;
    s1_spi_rd_nxt_s = issue_spi_s && !pend_we_r;
    // Writes finish once the enable has been presented; reads after capture
    busy_nxt_s      = pend_valid_nxt_s || issue_spi_s || s1_spi_rd_r;
  end

  // Pending SPI slot capture; write wins when both strobes are high
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_valid_r <= 1'b0;
      pend_we_r    <= 1'b0;
      pend_addr_r  <= '0;
      pend_wdata_r <= 8'h00;
    end else begin
      pend_valid_r <= pend_valid_nxt_s;
      if (match_s) begin
        pend_we_r    <= spi_wr;
        pend_addr_r  <= spi_addr[c_bram_bits-1:0];
        pend_wdata_r <= spi_wdata;
      end else begin
        pend_we_r    <= pend_we_r;
        pend_addr_r  <= pend_addr_r;
        pend_wdata_r <= pend_wdata_r;
      end
    end
  end

  // Pipeline stage tracking and video in-flight flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vid_inflight_r <= 1'b0;
      s1_vid_r       <= 1'b0;
      s2_vid_r       <= 1'b0;
      s1_spi_r       <= 1'b0;
      s1_spi_rd_r    <= 1'b0;
      s2_spi_rd_r    <= 1'b0;
    end else begin
      s1_vid_r    <= issue_vid_s;
      s2_vid_r    <= s1_vid_r;
      s1_spi_r    <= issue_spi_s;
      s1_spi_rd_r <= s1_spi_rd_nxt_s;
      s2_spi_rd_r <= s1_spi_rd_r;
      if (issue_vid_s) begin
        vid_inflight_r <= 1'b1;
      end else if (s2_vid_r) begin
        vid_inflight_r <= 1'b0;
      end else begin
        vid_inflight_r <= vid_inflight_r;
      end
    end
  end

  // BRAM port registers; address holds when the slot is idle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bram_addr_r  <= '0;
      bram_we_r    <= 1'b0;
      bram_wdata_r <= 8'h00;
    end else begin
      bram_we_r <= issue_spi_s && pend_we_r;
      if (issue_vid_s) begin
        bram_addr_r  <= vid_addr;
        bram_wdata_r <= bram_wdata_r;
      end else if (issue_spi_s) begin
        bram_addr_r  <= pend_addr_r;
        bram_wdata_r <= pend_wdata_r;
      end else begin
        bram_addr_r  <= bram_addr_r;
        bram_wdata_r <= bram_wdata_r;
      end
    end
  end

  // Read-data capture, ack pulse, busy and sticky overrun flag
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vid_ack_r     <= 1'b0;
      vid_rdata_r   <= 8'h00;
      spi_rdata_r   <= 8'h00;
      spi_busy_r    <= 1'b0;
      spi_overrun_r <= 1'b0;
    end else begin
      vid_ack_r  <= s2_vid_r;
      spi_busy_r <= busy_nxt_s;
      if (s2_vid_r) begin
        vid_rdata_r <= bram_rdata;
      end else begin
        vid_rdata_r <= vid_rdata_r;
      end
      if (s2_spi_rd_r) begin
        spi_rdata_r <= bram_rdata;
      end else begin
        spi_rdata_r <= spi_rdata_r;
      end
      if (overrun_set_s) begin
        spi_overrun_r <= 1'b1;
      end else if (overrun_clr) begin
        spi_overrun_r <= 1'b0;
      end else begin
        spi_overrun_r <= spi_overrun_r;
      end
    end
  end

`ifdef OSD_ARB_STATS_EN
  logic [15:0] stat_wait_r;

  // Count edges where SPI work was waiting (or arriving) but video took the slot
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_wait_r <= 16'h0000;
    end else if (issue_vid_s && (pend_valid_r || match_s) && (stat_wait_r != 16'hFFFF)) begin
      stat_wait_r <= stat_wait_r + 16'd1;
    end else begin
      stat_wait_r <= stat_wait_r;
    end
  end

  assign stat_wait = stat_wait_r;
`else
  assign stat_wait = 16'h0000;
`endif

  assign spi_rdata   = spi_rdata_r;
  assign spi_busy    = spi_busy_r;
  assign spi_overrun = spi_overrun_r;
  assign vid_ack     = vid_ack_r;
  assign vid_rdata   = vid_rdata_r;
  assign bram_addr   = bram_addr_r;
  assign bram_we     = bram_we_r;
  assign bram_wdata  = bram_wdata_r;

endmodule

// File: tb/tb_osd_bram_arbiter.sv
// Directed testbench for osd_bram_arbiter with a behavioural 1-cycle BRAM.
module tb_osd_bram_arbiter;

  logic        clk;
  logic        rstn;
  logic        spi_rd;
  logic        spi_wr;
  logic [31:0] spi_addr;
  logic [7:0]  spi_wdata;
  logic [7:0]  spi_rdata;
  logic        spi_busy;
  logic        spi_overrun;
  logic        overrun_clr;
  logic        vid_req;
  logic [11:0] vid_addr;
  logic        vid_ack;
  logic [7:0]  vid_rdata;
  logic [11:0] bram_addr;
  logic        bram_we;
  logic [7:0]  bram_wdata;
  logic [7:0]  bram_rdata;
  logic [15:0] stat_wait;

  // Bench-side preload port into the BRAM model
  logic        pre_we;
  logic [11:0] pre_addr;
  logic [7:0]  pre_data;
  logic [7:0]  mem [0:4095];

  int n_checks = 0;
  int n_fail   = 0;

`ifdef OSD_ARB_STATS_EN
  localparam logic [15:0] STAT_AFTER_VID = 16'd1;
  localparam logic [15:0] STAT_AFTER_OVR = 16'd2;
`else
  localparam logic [15:0] STAT_AFTER_VID = 16'd0;
  localparam logic [15:0] STAT_AFTER_OVR = 16'd0;
`endif

  osd_bram_arbiter dut (
    .clk(clk), .rstn(rstn),
    .spi_rd(spi_rd), .spi_wr(spi_wr), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_rdata(spi_rdata), .spi_busy(spi_busy), .spi_overrun(spi_overrun),
    .overrun_clr(overrun_clr),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
    .bram_addr(bram_addr), .bram_we(bram_we), .bram_wdata(bram_wdata),
    .bram_rdata(bram_rdata), .stat_wait(stat_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read single-port BRAM model
  always @(posedge clk) begin
    bram_rdata <= mem[bram_addr];
    if (bram_we) mem[bram_addr] <= bram_wdata;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end

  task preset(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task test_reset;
    rstn = 1'b0;
    spi_rd = 1'b0; spi_wr = 1'b0; spi_addr = 32'h0; spi_wdata = 8'h00;
    overrun_clr = 1'b0; vid_req = 1'b0; vid_addr = 12'h000;
    pre_we = 1'b0; pre_addr = 12'h000; pre_data = 8'h00;
    preset(12'h000, 8'h00);
    preset(12'h040, 8'hC3);
    preset(12'h123, 8'h00);
    preset(12'h2A7, 8'h96);
    preset(12'h300, 8'h00);
    preset(12'h301, 8'h00);
    preset(12'h155, 8'h33);
    n_checks++; if (bram_addr !== 12'h000) begin n_fail++; $display("FAIL rst_bram_addr: got %h want 000", bram_addr); end
    n_checks++; if (bram_we !== 1'b0) begin n_fail++; $display("FAIL rst_bram_we: got %b want 0", bram_we); end
    n_checks++; if (bram_wdata !== 8'h00) begin n_fail++; $display("FAIL rst_bram_wdata: got %h want 00", bram_wdata); end
    n_checks++; if (vid_ack !== 1'b0) begin n_fail++; $display("FAIL rst_vid_ack: got %b want 0", vid_ack); end
    n_checks++; if (vid_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_vid_rdata: got %h want 00", vid_rdata); end
    n_checks++; if (spi_rdata !== 8'h00) begin n_fail++; $display("FAIL rst_spi_rdata: got %h want 00", spi_rdata); end
    n_checks++; if (spi_busy !== 1'b0) begin n_fail++; $display("FAIL rst_spi_busy: got %b want 0", spi_busy); end
    n_checks++; if (spi_overrun !== 1'b0) begin n_fail++; $display("FAIL rst_spi_overrun: got %b want 0", spi_overrun); end
    n_checks++; if (stat_wait !== 16'h0000) begin n_fail++; $display("FAIL rst_stat_wait: got %h want 0000", stat_wait); end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task test_spi_write;
    @(negedge clk);
    spi_wr = 1'b1; spi_addr = 32'hFD000123; spi_wdata = 8'h5A;
    @(negedge clk);
    spi_wr = 1'b0;
    n_checks++; if ({spi_busy, bram_we} !== 2'b10) begin n_fail++; $display("FAIL wr_capture: busy,we got %b want 10", {spi_busy, bram_we}); end
    @(negedge clk);
    n_checks++; if ({bram_we, bram_addr, bram_wdata} !== {1'b1, 12'h123, 8'h5A}) begin n_fail++; $display("FAIL wr_issue: we,addr,wdata got %b %h %h want 1 123 5a", bram_we, bram_addr, bram_wdata); end
    n_checks++; if (spi_busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy_issue: got %b want 1", spi_busy); end
    @(negedge clk);
    n_checks++; if ({bram_we, spi_busy} !== 2'b00) begin n_fail++; $display("FAIL wr_done: we,busy got %b want 00", {bram_we, spi_busy}); end
  endtask

  task test_spi_read;
    int got_at;
    got_at = 0;
    @(negedge clk);
    spi_rd = 1'b1; spi_addr = 32'hFD000123;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      spi_rd = 1'b0;
      if (got_at == 0 && spi_rdata === 8'h5A) got_at = k;
    end
    n_checks++; if (got_at == 0 || got_at > 4) begin n_fail++; $display("FAIL rd_latency: spi_rdata=%h after 4 clk, want 5a", spi_rdata); end
    n_checks++; if (spi_busy !== 1'b0) begin n_fail++; $display("FAIL rd_busy_end: got %b want 0", spi_busy); end
    @(negedge clk);
    spi_rd = 1'b1; spi_addr = 32'hFB000000;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      spi_rd = 1'b0;
      n_checks++;
      if ({spi_busy, bram_we, bram_addr, spi_rdata} !== {1'b0, 1'b0, 12'h123, 8'h5A}) begin
        n_fail++;
        $display("FAIL rd_nomatch: busy,we,addr,rdata got %b %b %h %h want 0 0 123 5a", spi_busy, bram_we, bram_addr, spi_rdata);
      end
    end
  endtask

  task test_video_spi;
    @(negedge clk);
    vid_req = 1'b1; vid_addr = 12'h040;
    spi_rd = 1'b1; spi_addr = 32'hFD0002A7;
    @(negedge clk);
    spi_rd = 1'b0;
    n_checks++; if ({bram_addr, spi_busy, vid_ack} !== {12'h040, 1'b1, 1'b0}) begin n_fail++; $display("FAIL vs_vid_first: addr,busy,ack got %h %b %b want 040 1 0", bram_addr, spi_busy, vid_ack); end
    @(negedge clk);
    n_checks++; if (bram_addr !== 12'h2A7) begin n_fail++; $display("FAIL vs_spi_next: addr got %h want 2a7", bram_addr); end
    for (int k = 3; k <= 9; k++) begin
      @(negedge clk);
      n_checks++;
      if (vid_ack !== ((k % 3) == 0)) begin n_fail++; $display("FAIL vs_ack_cadence: cycle %0d ack got %b want %b", k, vid_ack, ((k % 3) == 0)); end
      if (k == 3) begin
        n_checks++; if (vid_rdata !== 8'hC3) begin n_fail++; $display("FAIL vs_vid_rdata: got %h want c3", vid_rdata); end
      end
      if (k == 4) begin
        n_checks++; if ({spi_rdata, spi_busy, bram_addr} !== {8'h96, 1'b0, 12'h040}) begin n_fail++; $display("FAIL vs_spi_rdata: rdata,busy,addr got %h %b %h want 96 0 040", spi_rdata, spi_busy, bram_addr); end
      end
    end
    vid_req = 1'b0;
    n_checks++; if (stat_wait !== STAT_AFTER_VID) begin n_fail++; $display("FAIL vs_stat_wait: got %0d want %0d", stat_wait, STAT_AFTER_VID); end
  endtask

  task test_overrun;
    @(negedge clk);
    spi_wr = 1'b1; spi_addr = 32'hFD000300; spi_wdata = 8'h11;
    @(negedge clk);
    spi_addr = 32'hFD000301; spi_wdata = 8'h22;
    vid_req = 1'b1; vid_addr = 12'h040;
    @(negedge clk);
    spi_wr = 1'b0;
    n_checks++; if ({spi_overrun, bram_we, spi_busy, bram_addr} !== {1'b1, 1'b0, 1'b1, 12'h040}) begin n_fail++; $display("FAIL ov_set: ovr,we,busy,addr got %b %b %b %h want 1 0 1 040", spi_overrun, bram_we, spi_busy, bram_addr); end
    @(negedge clk);
    n_checks++; if ({bram_we, bram_addr, bram_wdata} !== {1'b1, 12'h301, 8'h22}) begin n_fail++; $display("FAIL ov_second_write: we,addr,wdata got %b %h %h want 1 301 22", bram_we, bram_addr, bram_wdata); end
    @(negedge clk);
    n_checks++; if ({bram_we, vid_ack, spi_overrun} !== 3'b011) begin n_fail++; $display("FAIL ov_hold: we,ack,ovr got %b want 011", {bram_we, vid_ack, spi_overrun}); end
    vid_req = 1'b0; overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    n_checks++; if (spi_overrun !== 1'b0) begin n_fail++; $display("FAIL ov_clear: got %b want 0", spi_overrun); end
    n_checks++; if ({mem[12'h300], mem[12'h301]} !== {8'h00, 8'h22}) begin n_fail++; $display("FAIL ov_mem: mem300,mem301 got %h %h want 00 22", mem[12'h300], mem[12'h301]); end
    n_checks++; if (stat_wait !== STAT_AFTER_OVR) begin n_fail++; $display("FAIL ov_stat_wait: got %0d want %0d", stat_wait, STAT_AFTER_OVR); end
  endtask

  task test_rd_wr_both;
    @(negedge clk);
    spi_rd = 1'b1; spi_wr = 1'b1; spi_addr = 32'hFD000155; spi_wdata = 8'h77;
    @(negedge clk);
    spi_rd = 1'b0; spi_wr = 1'b0;
    @(negedge clk);
    n_checks++; if ({bram_we, bram_addr, bram_wdata} !== {1'b1, 12'h155, 8'h77}) begin n_fail++; $display("FAIL both_write: we,addr,wdata got %b %h %h want 1 155 77", bram_we, bram_addr, bram_wdata); end
    @(negedge clk);
    n_checks++; if ({bram_we, spi_busy} !== 2'b00) begin n_fail++; $display("FAIL both_done: we,busy got %b want 00", {bram_we, spi_busy}); end
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (spi_rdata !== 8'h96) begin n_fail++; $display("FAIL both_no_read: spi_rdata got %h want 96", spi_rdata); end
    n_checks++; if (mem[12'h155] !== 8'h77) begin n_fail++; $display("FAIL both_mem: got %h want 77", mem[12'h155]); end
  endtask

  task test_reset_midflight;
    @(negedge clk);
    vid_req = 1'b1; vid_addr = 12'h040;
    @(negedge clk);
    n_checks++; if (bram_addr !== 12'h040) begin n_fail++; $display("FAIL mr_issued: addr got %h want 040", bram_addr); end
    rstn = 1'b0; vid_req = 1'b0;
    #1;
    n_checks++;
    if ({bram_addr, bram_we, bram_wdata, vid_ack, vid_rdata, spi_rdata, spi_busy, spi_overrun, stat_wait} !==
        {12'h000, 1'b0, 8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL mr_reset_vals: addr %h we %b wd %h ack %b vrd %h srd %h busy %b ovr %b stat %h, want all zero",
               bram_addr, bram_we, bram_wdata, vid_ack, vid_rdata, spi_rdata, spi_busy, spi_overrun, stat_wait);
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++; if ({vid_ack, vid_rdata} !== {1'b0, 8'h00}) begin n_fail++; $display("FAIL mr_no_ack: cycle %0d ack,rdata got %b %h want 0 00", k, vid_ack, vid_rdata); end
    end
  endtask

  initial begin
    test_reset;
    test_spi_write;
    test_spi_read;
    test_video_spi;
    test_overrun;
    test_rd_wr_both;
    test_reset_midflight;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/osd_bram_arbiter.md
# osd_bram_arbiter

Shares one single-port OSD character/attribute BRAM (synchronous read, 1-cycle latency) between two requesters. The first is the SPI RAM slave port, which issues sparse one-cycle `rd`/`wr` strobes. The second is the real-time OSD video fetcher, which uses a level-request/ack handshake. Video has fixed priority; SPI accesses are latched and slotted into free cycles, with deterministic worst-case latency. The block sits between the SPI RAM slave and the OSD BRAM in the dvi_osd design.

## Interface
- `c_addr_bits`, 32, SPI address width
- `c_bram_bits`, 12, BRAM address width
- `c_addr_osd`, 8'hFD, SPI high address byte that selects the OSD BRAM window
- `clk`  in  1  system clock, faster than SCLK
- `rstn`  in  1  asynchronous active-low reset
- `spi_rd`  in  1  SPI read strobe, 1 clk pulse
- `spi_wr`  in  1  SPI write strobe, 1 clk pulse
- `spi_addr`  in  c_addr_bits  SPI byte address
- `spi_wdata`  in  8  SPI write byte
- `spi_rdata`  out  8  last SPI read result, held between reads
- `spi_busy`  out  1  SPI access pending or in flight
- `spi_overrun`  out  1  sticky: a pending SPI access was overwritten
- `overrun_clr`  in  1  clears `spi_overrun`
- `vid_req`  in  1  video read request, level
- `vid_addr`  in  c_bram_bits  video read address, stable while `vid_req` is high until ack
- `vid_ack`  out  1  1-cycle pulse; `vid_rdata` valid
- `vid_rdata`  out  8  video read data, held until next ack
- `bram_addr`  out  c_bram_bits  registered BRAM address
- `bram_we`  out  1  registered BRAM write enable
- `bram_wdata`  out  8  registered BRAM write data
- `bram_rdata`  in  8  BRAM read data, valid 1 cycle after address
- `stat_wait`  out  16  SPI wait-cycle counter (see Configuration)

## Operation
- SPI capture:
  - Strobe with `spi_addr[c_addr_bits-1:c_addr_bits-8] == c_addr_osd` loads the pending register: op, `spi_addr[c_bram_bits-1:0]`, `spi_wdata`.
  - Non-matching strobes are ignored; `spi_rdata` is unchanged.
  - `spi_rd` and `spi_wr` high together: write wins.
- Overrun: a matching strobe while the previous access is still pending (not yet issued) replaces it and sets `spi_overrun`. A strobe while an access is only in flight (already issued) is legal.
- Issue slot, evaluated every edge:
  - If `vid_req` is high and no video access is in flight, issue VID.
  - Else if SPI is pending, issue SPI.
  - Else NONE.
- Video in-flight flag: set on VID issue, cleared on the `vid_ack` edge. No second VID issue occurs while it is set, even though `vid_req` is still high.
- Issue pipeline (E0 = issue edge):
  - E0: `bram_addr`/`bram_we`/`bram_wdata` are registered.
  - E1: the BRAM returns data.
  - E2: capture. VID: `vid_rdata`<=`bram_rdata`, `vid_ack`<=1. SPI read: `spi_rdata`<=`bram_rdata`.
- `bram_we` is high for exactly one cycle per SPI write and is 0 otherwise.
- `bram_addr` holds its last value when the slot is idle.
- `spi_busy` is high from the capture edge through the E2 capture (read) or E1 (write).
- `spi_overrun`: `overrun_clr` clears it. A set and a clear on the same edge → the set wins.
- Reset (async, any time): all registers clear, pending and in-flight accesses are dropped, and no ack is issued afterwards.

## Timing
- Reset values: `bram_addr`=0, `bram_we`=0, `bram_wdata`=0, `vid_ack`=0, `vid_rdata`=0, `spi_rdata`=0, `spi_busy`=0, `spi_overrun`=0, `stat_wait`=0.
- Video latency: `vid_req` sampled high at edge E0 → `vid_ack` high in the cycle after E2. Peak rate is 1 access per 3 cycles.
- SPI latency:
  - Strobe sampled at edge S → earliest issue at S+1, worst case S+2 (video wins S+1 and is then in flight).
  - Read data lands in `spi_rdata` 2 edges after issue, i.e. at most 4 clk after the strobe, well inside the dummy-byte window.
- Simultaneous VID issue and SPI capture on the same edge is legal; the SPI access is issued on the next edge.

## Configuration
- `OSD_ARB_STATS_EN` defined: `stat_wait` increments, saturating at 16'hFFFF, on every edge where an SPI access is pending but VID is issued. It is cleared only by reset.
- `OSD_ARB_STATS_EN` undefined: `stat_wait` is constant 0 and the counter logic is not built.

## Test plan
- SPI write 0xFD000123 ← 0x5A, no video → `bram_we`=1 for one cycle with `bram_addr`=0x123 and `bram_wdata`=0x5A; `spi_busy` then returns to 0.
- SPI read 0xFD000123 with `bram_rdata` model 0x5A → `spi_rdata`=0x5A within 4 clk of the strobe; a read of 0xFB000000 leaves `spi_rdata`, `bram_*` and `spi_busy` untouched.
- `vid_req` held high continuously at addr 0x040 plus an SPI read strobe on the same edge → VID issued first, SPI issued on the next edge, `vid_ack` every 3 cycles, both return correct data; `stat_wait`=1 with `OSD_ARB_STATS_EN`, 0 without.
- Two matching SPI write strobes on consecutive edges while video is in issue → only the second write reaches BRAM; `spi_overrun`=1 until a `overrun_clr` pulse sets it to 0.
- `spi_rd` and `spi_wr` together → only the write is performed.
- `rstn` pulsed low between issue and capture of a video read → `vid_ack` never pulses for that request and all outputs read their reset values.
